// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle for the multi-cycle mult/div unit.
//   Start, ALU_Control, A, B : request side (driven by the datapath/master)
//   HI, LO                   : result registers
//   Busy, Done, DivZero      : status (registered in the unit)
interface mul_div_unit_if;
  logic        Start;
  logic [3:0]  ALU_Control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Busy;
  logic        Done;
  logic        DivZero;

  modport master (output Start, ALU_Control, A, B,
                  input  HI, LO, Busy, Done, DivZero);
  modport slave  (input  Start, ALU_Control, A, B,
                  output HI, LO, Busy, Done, DivZero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed 32x32 multiply (shift-add) and signed
// 32/32 divide (restoring), both run on magnitudes with the signs fixed
// up in a final cycle. HI/LO only change when a result is written.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : slave side of mul_div_unit_if (request in, HI/LO/status out)
module mul_div_unit (
  input  logic      Clk,
  input  logic      Reset,
  mul_div_unit_if.slave bus
);
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b1011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_n;

  logic [5:0]  cnt;
  logic [31:0] acc_hi;   // product high half / partial remainder
  logic [31:0] acc_lo;   // multiplier (shifting out) / dividend->quotient
  logic [31:0] opb;      // multiplicand magnitude / divisor magnitude
  logic        is_div, neg_res, neg_a, dz;
  logic [31:0] hi_r, lo_r;
  logic        busy_r, done_r, dz_r;

  logic        accept, accept_dz;
  logic [31:0] a_mag, b_mag;
  logic [32:0] m_sum, d_sh;
  logic        d_ge;
  logic [31:0] d_rem;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  assign accept    = (state == IDLE) && bus.Start &&
                     ((bus.ALU_Control == OP_MUL) || (bus.ALU_Control == OP_DIV));
  assign accept_dz = accept && (bus.ALU_Control == OP_DIV) && (bus.B == 32'd0);
  assign a_mag     = bus.A[31] ? (32'd0 - bus.A) : bus.A;
  assign b_mag     = bus.B[31] ? (32'd0 - bus.B) : bus.B;

  // One iteration of each algorithm.
  assign m_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign d_sh  = {acc_hi, acc_lo[31]};
  assign d_ge  = d_sh >= {1'b0, opb};
  // When d_ge holds the difference is below opb, so 32 bits suffice.
  assign d_rem = d_sh[31:0] - opb;

  // Sign fix-up: quotient truncates toward zero, remainder follows A.
  assign prod = neg_res ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
  assign quo  = neg_res ? (32'd0 - acc_lo) : acc_lo;
  assign rem  = neg_a   ? (32'd0 - acc_hi) : acc_hi;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = accept_dz ? FIX : RUN;
      // 32 iterating cycles (cnt 0..31) plus one settle cycle at cnt==32.
      RUN:  if (cnt == 6'd32) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      dz      <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      state  <= state_n;
      busy_r <= (state_n != IDLE);
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          is_div  <= (bus.ALU_Control == OP_DIV);
          neg_a   <= bus.A[31];
          neg_res <= bus.A[31] ^ bus.B[31];
          cnt     <= '0;
          acc_hi  <= '0;
          dz      <= accept_dz;
          if (bus.ALU_Control == OP_DIV) begin
            acc_lo <= a_mag;
            opb    <= b_mag;
          end else begin
            acc_lo <= b_mag;
            opb    <= a_mag;
          end
          // Divide-by-zero reports in the single busy cycle, no result write.
          done_r <= accept_dz;
          dz_r   <= accept_dz;
        end
        RUN: if (cnt != 6'd32) begin
          cnt <= cnt + 6'd1;
          if (is_div) begin
            acc_hi <= d_ge ? d_rem : d_sh[31:0];
            acc_lo <= {acc_lo[30:0], d_ge};
          end else begin
            acc_hi <= m_sum[32:1];
            acc_lo <= {m_sum[0], acc_lo[31:1]};
          end
        end
        FIX: if (!dz) begin
          hi_r   <= is_div ? rem : prod[63:32];
          lo_r   <= is_div ? quo : prod[31:0];
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;
  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;
  assign bus.DivZero = dz_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed cases plus randomized ops against a reference
// model built on 64-bit signed arithmetic.
module tb_mul_div_unit;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b1011;

  logic Clk = 1'b0;
  logic Reset;
  mul_div_unit_if bus();

  mul_div_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain signed arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = m_hi; el = m_lo; edz = 1'b0;
    if (op == OP_MUL) begin
      p = sa * sb;
      eh = p[63:32]; el = p[31:0];
    end else if (b == 32'd0) begin
      edz = 1'b1;
    end else begin
      q = sa / sb; r = sa % sb;
      el = q[31:0]; eh = r[31:0];
    end
  endtask

  // Called at a negedge; returns at the negedge of the Done cycle.
  // inj >= 0 pulses a competing div request while the op is in flight.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj);
    logic [31:0] eh, el;
    logic edz;
    int done_at, busy_n;
    logic stable;
    model(op, a, b, eh, el, edz);
    bus.Start = 1'b1; bus.ALU_Control = op; bus.A = a; bus.B = b;
    @(posedge Clk);
    done_at = -1; busy_n = 0; stable = 1'b1;
    for (int i = 0; i < 60 && done_at < 0; i++) begin
      @(negedge Clk);
      if (i == 0) bus.Start = 1'b0;
      if (i == inj) begin
        bus.Start = 1'b1; bus.ALU_Control = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
      end
      if (inj >= 0 && i == inj + 1) bus.Start = 1'b0;
      if (bus.Done) done_at = i;
      else begin
        if (bus.Busy) busy_n++;
        if (bus.HI !== m_hi || bus.LO !== m_lo) stable = 1'b0;
      end
    end
    chk("done_at", done_at, edz ? 0 : 34);
    chk("busy_cycles", busy_n, edz ? 0 : 34);
    chk("busy_at_done", bus.Busy, edz);
    chk("divzero", bus.DivZero, edz);
    chk("hilo_stable", stable, 1);
    chk("hi", bus.HI, eh);
    chk("lo", bus.LO, el);
    m_hi = eh; m_lo = el;
  endtask

  task automatic idle();
    @(negedge Clk);
    chk("idle_done", bus.Done, 0);
    chk("idle_busy", bus.Busy, 0);
  endtask

  function automatic logic [31:0] pick(input logic allow_zero);
    case ($urandom_range(0, 6))
      0: pick = allow_zero ? 32'd0 : 32'd1;
      1: pick = 32'h8000_0000;
      2: pick = 32'hFFFF_FFFF;
      3: pick = $urandom_range(0, 20);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int cnt;
    logic [3:0] op;
    Reset = 1'b1; bus.Start = 1'b0; bus.ALU_Control = 4'd0; bus.A = '0; bus.B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge Clk);
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_divzero", bus.DivZero, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Signed mult / div sign rules.
    do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, -1);           idle();
    chk("mul_neg_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mul_neg_lo", bus.LO, 32'hFFFF_FFEB);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);           idle();
    chk("div_neg_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.HI, 32'hFFFF_FFFF);
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, -1);           idle();
    chk("div_negb_hi", bus.HI, 32'd1);

    // Divide by zero leaves HI/LO untouched.
    do_op(OP_MUL, 32'h5555_5556, 32'h3333_3333, -1);   idle();
    do_op(OP_DIV, 32'd5, 32'd0, -1);                   idle();

    // Unsupported codes are ignored.
    bus.Start = 1'b1; bus.ALU_Control = 4'b0100; bus.A = 32'd9; bus.B = 32'd3;
    @(negedge Clk);
    bus.Start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.Busy || bus.Done) cnt++;
      @(negedge Clk);
    end
    chk("badcode_activity", cnt, 0);
    chk("badcode_lo", bus.LO, m_lo);

    // Start while busy is ignored; exactly one Done.
    do_op(OP_MUL, 32'd3, 32'd4, 10);
    chk("ignored_lo", bus.LO, 12);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (bus.Done) cnt++;
    end
    chk("no_second_done", cnt, 0);

    // Reset mid-operation aborts.
    bus.Start = 1'b1; bus.ALU_Control = OP_MUL; bus.A = 32'hFFFF_FFFF; bus.B = 32'hFFFF_FFFF;
    @(posedge Clk);
    repeat (20) @(negedge Clk);
    bus.Start = 1'b0;
    Reset = 1'b1;
    #1;
    chk("abort_hi", bus.HI, 0);
    chk("abort_lo", bus.LO, 0);
    chk("abort_busy", bus.Busy, 0);
    m_hi = '0; m_lo = '0;
    @(negedge Clk);
    Reset = 1'b0;
    do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("rerun_lo", bus.LO, 1);

    // Overflow div, then back-to-back mult started in the Done cycle.
    idle();
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("ovf_lo", bus.LO, 32'h8000_0000);
    do_op(OP_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
    chk("b2b_hi", bus.HI, 32'h3FFF_FFFF);
    idle();

    // Randomized ops.
    for (int n = 0; n < 24; n++) begin
      op = ($urandom_range(0, 1) != 0) ? OP_MUL : OP_DIV;
      do_op(op, pick(1'b1), pick(1'b1), -1);
      idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Start, input, 1, request to begin the operation named by ALU_Control.
REQ-004 SHALL have port ALU_Control, input, 4, operation code: 4'b0101 = signed mult, 4'b1011 = signed div; all other codes are not operations of this block.
REQ-005 SHALL have port A, input, 32, rs operand (multiplicand / dividend), two's complement.
REQ-006 SHALL have port B, input, 32, rt operand (multiplier / divisor), two's complement.
REQ-007 SHALL have port HI, output, 32, HI register: product[63:32] or remainder.
REQ-008 SHALL have port LO, output, 32, LO register: product[31:0] or quotient.
REQ-009 SHALL have port Busy, output, 1, registered; high while an operation is in flight; the datapath stalls on it.
REQ-010 SHALL have port Done, output, 1, registered single-cycle pulse in the first cycle HI/LO hold a new result.
REQ-011 SHALL have port DivZero, output, 1, registered; pulses with Done when a div had B == 0.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX; Busy = (state != IDLE).
REQ-013 In IDLE, Start=1 with a valid code SHALL latch |A|, |B|, result signs and op at the edge; the state then moves to RUN with iteration count 0.
REQ-014 In IDLE, Start=1 with any other code SHALL be ignored: no state change, no Done.
REQ-015 Start while Busy=1 SHALL be ignored; the latched operands and op SHALL be unaffected.
REQ-016 mult SHALL use unsigned shift-add on magnitudes for exactly 32 RUN cycles (one multiplier bit per cycle), forming a 64-bit magnitude.
REQ-017 div SHALL use unsigned restoring division on magnitudes for exactly 32 RUN cycles (one quotient bit per cycle).
REQ-018 After RUN, FIX SHALL take one cycle: apply signs and write HI/LO at the FIX-exit edge.
REQ-019 mult sign: the 64-bit product SHALL be negated when sign(A) != sign(B); HI = [63:32], LO = [31:0].
REQ-020 div sign: the quotient SHALL truncate toward zero and be negated when sign(A) != sign(B); the remainder SHALL take the sign of A.
REQ-021 Latency: with Start accepted at edge k, Busy SHALL be 1 from edge k to edge k+34; HI/LO SHALL update at edge k+34; Done SHALL be 1 for exactly the cycle after edge k+34; Busy SHALL be 0 in that cycle.
REQ-022 A new Start SHALL be accepted in the Done cycle (back-to-back operation).
REQ-023 div with B == 0: RUN/FIX SHALL be skipped; HI/LO SHALL be unchanged; Done and DivZero SHALL pulse one cycle after the accept edge; Busy SHALL be high for that one cycle only.
REQ-024 Overflow: 0x80000000 div 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000; there is no trap.
REQ-025 HI/LO SHALL change only at FIX exit; intermediate values SHALL never appear on HI/LO.

Reset
REQ-026 Reset=1 SHALL force, asynchronously: state=IDLE, HI=0, LO=0, Busy=0, Done=0, DivZero=0, internal accumulators/count = 0.
REQ-027 Reset asserted mid-operation SHALL abort it with no result written; after release the block SHALL accept Start normally.

Verification
REQ-028 mult A=7, B=0xFFFFFFFD (-3) -> at k+34 HI=0xFFFFFFFF, LO=0xFFFFFFEB; Done pulse 1 cycle; Busy high 34 cycles.
REQ-029 div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then div A=7, B=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=0x00000001.
REQ-030 div A=5, B=0 with prior HI/LO=0x11111111/0x22222222 -> HI/LO unchanged; Done=DivZero=1 in the cycle after accept.
REQ-031 Start mult 3*4, then Start div 100/7 at cycle k+10 -> second request ignored; LO=12, HI=0; no second Done.
REQ-032 Reset at cycle k+20 of mult 0xFFFFFFFF*0xFFFFFFFF -> HI=LO=0 and Busy=0 immediately; rerun the same op -> HI=0, LO=1.
REQ-033 div 0x80000000/0xFFFFFFFF, then back-to-back mult 0x7FFFFFFF*0x7FFFFFFF started in the Done cycle -> LO=0x80000000, HI=0, then HI=0x3FFFFFFF, LO=0x00000001.
